filter_step_sequencer: RTL and testbench

//  Drives the emulated filter's v_in through a programmed table of step levels.

---
 rtl/filter_step_seq_pkg.sv | 38 +++
 rtl/filter_step_sequencer_settle_detector.sv | 77 +++++++
 rtl/filter_step_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_filter_step_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_step_seq_pkg.sv
// -----------------------------------------------------------------------------
// filter_step_seq_pkg
// Shared definitions for the filter step-response sequencer.
//   - default parameter values used by filter_step_sequencer / settle_detector
//   - state_t   : sequencer FSM states
//   - level_t   : signed v_in/v_out code at the default width
//   - diff_t    : one bit wider than level_t so v_out[n]-v_out[n-1] never wraps
//   - result_t  : one per-step result record (step, cycles, value, timeout)
// No ports (package).
// -----------------------------------------------------------------------------
package filter_step_seq_pkg;

  localparam int WIDTH_DEF      = 25;
  localparam int N_STEPS_DEF    = 4;
  localparam int CNT_W_DEF      = 16;
  localparam int TOL_DEF        = 4;
  localparam int SETTLE_CNT_DEF = 8;
  localparam int MAX_WAIT_DEF   = 4000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    WAIT   = 3'd2,
    RECORD = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef logic signed [WIDTH_DEF-1:0] level_t;
  typedef logic signed [WIDTH_DEF:0]   diff_t;

  typedef struct packed {
    logic [$clog2(N_STEPS_DEF)-1:0] step;
    logic [CNT_W_DEF-1:0]           cycles;
    level_t                         value;
    logic                           timeout;
  } result_t;

endpackage

// File: rtl/filter_step_sequencer_settle_detector.sv
// -----------------------------------------------------------------------------
// settle_detector
// Tracks successive v_out samples and decides when the filter output has
// settled: |v_out[n] - v_out[n-1]| <= TOL for SETTLE_CNT consecutive cycles.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : re-arm (v_prev <= v_out, run counter <= 0); used when a new
//               level is applied
//   enable    : one observation cycle (compare, advance/clear run counter)
//   v_out     : filter output sample
//   v_prev    : last sampled v_out (holds while neither clear nor enable)
//   settled   : combinational; high in the observation cycle that completes
//               the SETTLE_CNT-long run of in-tolerance differences
// -----------------------------------------------------------------------------
module settle_detector #(
  parameter int WIDTH      = 25,
  parameter int TOL        = 4,
  parameter int SETTLE_CNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] v_out,
  output logic signed [WIDTH-1:0] v_prev,
  output logic                    settled
);
  import filter_step_seq_pkg::*;

  localparam int SC_W = $clog2(SETTLE_CNT + 1);

  logic signed [WIDTH-1:0] v_prev_q;
  logic [SC_W-1:0]         stable_cnt_q;
  logic [SC_W-1:0]         stable_cnt_d;
  logic signed [WIDTH:0]   diff;
  logic [WIDTH:0]          diff_mag;
  logic                    in_tol;

  // Sign-extend both operands by one bit: the difference of two WIDTH-bit
  // signed codes always fits in WIDTH+1 bits, and so does its magnitude.
  always_comb begin
    diff     = {v_out[WIDTH-1], v_out} - {v_prev_q[WIDTH-1], v_prev_q};
    diff_mag = diff[WIDTH] ? -diff : diff;
    in_tol   = (diff_mag <= (WIDTH+1)'(TOL));
  end

  always_comb begin
    stable_cnt_d = stable_cnt_q;
    if (clear) begin
      stable_cnt_d = '0;
    end else if (enable) begin
      if (in_tol) begin
        // Saturate so a long quiet stretch cannot wrap back to zero.
        stable_cnt_d = (stable_cnt_q == SC_W'(SETTLE_CNT)) ? stable_cnt_q
                                                             : stable_cnt_q + 1'b1;
      end else begin
        stable_cnt_d = '0;
      end
    end
  end

  assign settled = enable && (stable_cnt_d == SC_W'(SETTLE_CNT));
  assign v_prev  = v_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_prev_q     <= '0;
      stable_cnt_q <= '0;
    end else begin
      stable_cnt_q <= stable_cnt_d;
      if (clear || enable) begin
        v_prev_q <= v_out;
      end
    end
  end

endmodule

// File: rtl/filter_step_sequencer.sv
// -----------------------------------------------------------------------------
// filter_step_sequencer
// Steps the emulated filter's input through a programmed table of levels and,
// for every step, reports how long v_out took to settle (or that it timed out)
// and the v_out value at that moment.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (also clears the table)
//   cfg_we       : table write strobe, honoured only while idle
//   cfg_addr     : table index
//   cfg_data     : signed step level
//   start        : run request, honoured only while idle
//   v_in         : registered signed drive to the filter input
//   v_out        : signed filter output sample
//   busy         : high from the cycle after start through the DONE cycle
//   done         : one-cycle pulse after the last step is recorded
//   res_valid    : one-cycle pulse per completed step
//   res_step     : step index of the result
//   res_cycles   : cycles from level applied to settled (or MAX_WAIT)
//   res_value    : v_out sampled in the last observation cycle
//   res_timeout  : step reached MAX_WAIT without settling
// -----------------------------------------------------------------------------
module filter_step_sequencer #(
  parameter int WIDTH      = 25,
  parameter int N_STEPS    = 4,
  parameter int CNT_W      = 16,
  parameter int TOL        = 4,
  parameter int SETTLE_CNT = 8,
  parameter int MAX_WAIT   = 4000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(N_STEPS)-1:0]   cfg_addr,
  input  logic signed [WIDTH-1:0]      cfg_data,
  input  logic                         start,
  output logic signed [WIDTH-1:0]      v_in,
  input  logic signed [WIDTH-1:0]      v_out,
  output logic                         busy,
  output logic                         done,
  output logic                         res_valid,
  output logic [$clog2(N_STEPS)-1:0]   res_step,
  output logic [CNT_W-1:0]             res_cycles,
  output logic signed [WIDTH-1:0]      res_value,
  output logic                         res_timeout
);
  import filter_step_seq_pkg::*;

  localparam int              AW         = $clog2(N_STEPS);
  localparam logic [AW-1:0]   LAST_STEP  = AW'(N_STEPS - 1);
  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  state_t                  state_q, state_d;
  logic [AW-1:0]           step_q, step_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic signed [WIDTH-1:0] v_in_q;
  logic signed [WIDTH-1:0] table_q [N_STEPS];

  logic [AW-1:0]           res_step_q;
  logic [CNT_W-1:0]        res_cycles_q;
  logic                    res_timeout_q;

  logic                    det_clear;
  logic                    det_en;
  logic                    det_settled;
  logic signed [WIDTH-1:0] det_v_prev;
  logic                    rec_load;
  logic                    rec_timeout;
  logic                    tbl_wr_en;

  // ---------------------------------------------------------------------------
  // Level table. Writes are dropped once a run is in progress; a write in the
  // same idle cycle as start lands before APPLY reads the table.
  // ---------------------------------------------------------------------------
  assign tbl_wr_en = cfg_we && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_STEPS; i++) begin
        table_q[i] <= '0;
      end
    end else if (tbl_wr_en) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Settle detection
  // ---------------------------------------------------------------------------
  settle_detector #(
    .WIDTH      (WIDTH),
    .TOL        (TOL),
    .SETTLE_CNT (SETTLE_CNT)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .clear   (det_clear),
    .enable  (det_en),
    .v_out   (v_out),
    .v_prev  (det_v_prev),
    .settled (det_settled)
  );

  // ---------------------------------------------------------------------------
  // FSM: next state and per-state controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    wait_cnt_d  = wait_cnt_q;
    det_clear   = 1'b0;
    det_en      = 1'b0;
    rec_load    = 1'b0;
    rec_timeout = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          step_d  = '0;
        end
      end

      APPLY: begin
        det_clear  = 1'b1;
        wait_cnt_d = '0;
        state_d    = WAIT;
      end

      WAIT: begin
        det_en     = 1'b1;
        wait_cnt_d = (wait_cnt_q == CNT_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
        // Settling wins over timeout when both land in the same cycle.
        if (det_settled) begin
          state_d  = RECORD;
          rec_load = 1'b1;
        end else if (wait_cnt_d == MAX_WAIT_C) begin
          state_d     = RECORD;
          rec_load    = 1'b1;
          rec_timeout = 1'b1;
        end
      end

      RECORD: begin
        if (step_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          step_d  = step_q + 1'b1;
          state_d = APPLY;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      step_q        <= '0;
      wait_cnt_q    <= '0;
      v_in_q        <= '0;
      res_step_q    <= '0;
      res_cycles_q  <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_q == APPLY) begin
        v_in_q <= table_q[step_q];
      end
      if (rec_load) begin
        res_step_q    <= step_q;
        res_cycles_q  <= wait_cnt_d;
        res_timeout_q <= rec_timeout;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign v_in        = v_in_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign res_valid   = (state_q == RECORD);
  assign res_step    = res_step_q;
  assign res_cycles  = res_cycles_q;
  assign res_timeout = res_timeout_q;
  // The detector samples v_out on every observation cycle and holds it through
  // RECORD, so its last sample is exactly the value at WAIT exit.
  assign res_value   = det_v_prev;

endmodule

// File: tb/tb_filter_step_sequencer.sv
module tb_filter_step_sequencer;

  localparam int WIDTH      = 25;
  localparam int N_STEPS    = 4;
  localparam int CNT_W      = 16;
  localparam int TOL        = 4;
  localparam int SETTLE_CNT = 8;
  localparam int MAX_WAIT   = 4000;
  localparam int AW         = $clog2(N_STEPS);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    cfg_we;
  logic [AW-1:0]           cfg_addr;
  logic signed [WIDTH-1:0] cfg_data;
  logic                    start;
  logic signed [WIDTH-1:0] v_in;
  logic signed [WIDTH-1:0] v_out = '0;
  logic                    busy;
  logic                    done;
  logic                    res_valid;
  logic [AW-1:0]           res_step;
  logic [CNT_W-1:0]        res_cycles;
  logic signed [WIDTH-1:0] res_value;
  logic                    res_timeout;

  filter_step_sequencer #(
    .WIDTH(WIDTH), .N_STEPS(N_STEPS), .CNT_W(CNT_W),
    .TOL(TOL), .SETTLE_CNT(SETTLE_CNT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .v_in(v_in), .v_out(v_out), .busy(busy), .done(done),
    .res_valid(res_valid), .res_step(res_step), .res_cycles(res_cycles),
    .res_value(res_value), .res_timeout(res_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard entry. vmode: 0 exact value, 1 |value|, 2 within TOL*SETTLE_CNT, 3 unchecked.
  typedef struct {
    int     step;
    longint cycles;   // -1: unchecked
    longint value;
    int     vmode;
    bit     timeout;
  } exp_t;
  exp_t sb_q[$];

  task automatic push_exp(input int s, input longint c, input longint v, input int vm, input bit to);
    exp_t e;
    e.step = s; e.cycles = c; e.value = v; e.vmode = vm; e.timeout = to;
    sb_q.push_back(e);
  endtask

  // v_out source: 0 constant, 1 toggle tog_a/tog_b, 2 first-order filter of v_in
  int     drv_mode  = 0;
  longint v_const   = 0;
  longint tog_a     = 0;
  longint tog_b     = 0;
  bit     tog_only0 = 1'b0;
  bit     tog_ph    = 1'b0;
  longint filt_y    = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rec_count    = 0;
  int done_count   = 0;
  int last_rec_cyc = 0;
  int done_cyc     = 0;

  // Monitor + v_out model; outputs sampled on the falling edge.
  always @(negedge clk) begin : mon
    exp_t   e;
    longint rv;
    if (res_valid) begin
      rec_count++;
      last_rec_cyc = cyc;
      rv = res_value;
      $display("res step=%0d cycles=%0d value=%0d timeout=%0d", res_step, res_cycles, rv, res_timeout);
      check("sb_pending", longint'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("res_step", res_step, e.step);
        if (e.cycles >= 0) check("res_cycles", res_cycles, e.cycles);
        check("res_timeout", res_timeout, e.timeout);
        case (e.vmode)
          0: check("res_value", rv, e.value);
          1: check("res_value_abs", (rv < 0) ? -rv : rv, e.value);
          2: check("res_value_near",
                   longint'((rv - e.value <= TOL*SETTLE_CNT) && (e.value - rv <= TOL*SETTLE_CNT)), 1);
          default: ;
        endcase
      end
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
    case (drv_mode)
      1: begin
        if (tog_only0 && res_valid && res_step == 0) begin
          drv_mode = 0;
          v_out    = WIDTH'(v_const);
        end else begin
          tog_ph = ~tog_ph;
          v_out  = WIDTH'(tog_ph ? tog_a : tog_b);
        end
      end
      2: begin
        filt_y = filt_y + ((longint'(v_in) - filt_y) >>> 3);
        v_out  = WIDTH'(filt_y);
      end
      default: v_out = WIDTH'(v_const);
    endcase
  end

  task automatic write_tbl(input int a, input longint d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = WIDTH'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One full run: checks first level, optional mid-run start/write injection,
  // done timing, result count and scoreboard drain.
  task automatic run(input longint lvl0, input int inject_at, input bit co_write, input longint co_data);
    int base_rec;
    int base_done;
    int t;
    base_rec  = rec_count;
    base_done = done_count;
    @(negedge clk);
    start = 1'b1;
    if (co_write) begin
      cfg_we = 1'b1; cfg_addr = '0; cfg_data = WIDTH'(co_data);
    end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    check("busy_after_start", busy, 1);
    @(negedge clk);
    check("v_in_first", v_in, lvl0);
    t = 0;
    while (done_count == base_done && t < 20000) begin
      @(posedge clk); #2;
      t++;
      if (t == inject_at) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = '0; cfg_data = WIDTH'(777);
      end else if (t == inject_at + 1) begin
        start = 1'b0; cfg_we = 1'b0;
      end
    end
    if (done_count == base_done) check("done_seen", 0, 1);
    else check("done_lat", done_cyc, last_rec_cyc + 1);
    check("res_count", rec_count - base_rec, N_STEPS);
    check("sb_drain", sb_q.size(), 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic push_uniform(input longint c, input longint v, input int vm);
    for (int s = 0; s < N_STEPS; s++) push_exp(s, c, v, vm, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_v_in", v_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_cycles", res_cycles, 0);
    check("rst_res_value", res_value, 0);
    check("rst_res_timeout", res_timeout, 0);
    rst = 1'b0;

    // 1: empty table, v_out constant 0
    push_uniform(8, 0, 0);
    run(0, 0, 1'b0, 0);

    // 2: programmed table, v_out constant 0
    write_tbl(0, 1000); write_tbl(1, -1000); write_tbl(2, 0); write_tbl(3, 500);
    push_uniform(8, 0, 0);
    run(1000, 0, 1'b0, 0);
    check("v_in_hold_last", v_in, 500);

    // 3: +5/-5 on step 0 -> timeout, then continues
    tog_a = 5; tog_b = -5; tog_only0 = 1'b1; v_const = 0; drv_mode = 1;
    push_exp(0, MAX_WAIT, 5, 1, 1'b1);
    for (int s = 1; s < N_STEPS; s++) push_exp(s, 8, 0, 0, 1'b0);
    run(1000, 0, 1'b0, 0);

    // 4a: |d| = TOL exactly is stable
    tog_a = 2; tog_b = -2; tog_only0 = 1'b0; drv_mode = 1;
    push_uniform(8, 2, 1);
    run(1000, 0, 1'b0, 0);

    // 4b: |d| = TOL+1 never settles
    tog_a = 2; tog_b = -3; tog_only0 = 1'b1; v_const = 0; drv_mode = 1;
    push_exp(0, MAX_WAIT, 0, 3, 1'b1);
    for (int s = 1; s < N_STEPS; s++) push_exp(s, 8, 0, 0, 1'b0);
    run(1000, 0, 1'b0, 0);

    // 5: start + cfg_we while busy are dropped
    drv_mode = 0; v_const = 321;
    push_uniform(8, 321, 0);
    run(1000, 5, 1'b0, 0);
    push_uniform(8, 321, 0);
    run(1000, 0, 1'b0, 0);

    // cfg_we with start in IDLE: new level used
    push_uniform(8, 321, 0);
    run(1234, 0, 1'b1, 1234);

    // 6: reset in WAIT of step 2
    write_tbl(2, 2222);
    begin
      int base_rec;
      int base_done;
      int t;
      base_rec = rec_count; base_done = done_count; t = 0;
      push_exp(0, 8, 321, 0, 1'b0);
      push_exp(1, 8, 321, 0, 1'b0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (rec_count < base_rec + 2 && t < 2000) begin
        @(posedge clk); #2; t++;
      end
      check("abort_reach", rec_count - base_rec, 2);
      repeat (2) @(negedge clk);
      check("abort_busy_pre", busy, 1);
      check("abort_v_in_pre", v_in, 2222);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_v_in", v_in, 0);
      check("abort_res_valid", res_valid, 0);
      check("abort_done", done, 0);
      repeat (3) @(negedge clk);
      check("abort_no_done", done_count - base_done, 0);
      check("abort_no_res", rec_count - base_rec, 2);
      check("abort_sb", sb_q.size(), 0);
    end
    // table cleared by reset -> level 0 everywhere
    push_uniform(8, 321, 0);
    run(0, 0, 1'b0, 0);

    // 7: closed loop with first-order filter model
    write_tbl(0, 16384); write_tbl(1, 0); write_tbl(2, -16384); write_tbl(3, 16384);
    filt_y = 0; drv_mode = 2;
    push_exp(0, -1, 16384, 2, 1'b0);
    push_exp(1, -1, 0, 2, 1'b0);
    push_exp(2, -1, -16384, 2, 1'b0);
    push_exp(3, -1, 16384, 2, 1'b0);
    run(16384, 0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
